// File: rtl/interleave_pkg.sv
`default_nettype none
// ============================================================================
// Module : interleave_pkg
// Sizing defaults, FSM state type and branch geometry for interleave_ctrl.
// Rev    : 1.0
// ============================================================================
package interleave_pkg;

  localparam int c_i  = 12;
  localparam int c_m  = 17;
  localparam int c_dw = 8;
  localparam int c_aw = 11;
  localparam int c_pw = 8;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Start of branch j's FIFO region in the shared RAM (regions packed in order)
  function automatic int branch_base(input int j, input int m);
    return m * j * (j - 1) / 2;
  endfunction

  function automatic int branch_depth(input int j, input int m);
    return j * m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/interleave_ptr_bank.sv
`default_nettype none
// ============================================================================
// Module : interleave_ptr_bank
// Per-branch FIFO pointers (branches 1..I-1) and RAM address generation.
// Rev    : 1.0
// ============================================================================
module interleave_ptr_bank
  import interleave_pkg::*;
#(
  parameter int I  = c_i,
  parameter int M  = c_m,
  parameter int AW = c_aw,
  parameter int PW = c_pw,
  parameter int BW = $clog2(c_i)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          adv,
  input  logic [BW-1:0] sel,
  output logic [AW-1:0] addr
);

  logic [PW-1:0] r_ptr [1:I-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 1; j < I; j++) r_ptr[j] <= '0;
    end else if (adv) begin
      for (int j = 1; j < I; j++) begin
        if (sel == BW'(j)) begin
          r_ptr[j] <= (r_ptr[j] == PW'(branch_depth(j, M) - 1)) ? '0 : r_ptr[j] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    addr = '0;
    for (int j = 1; j < I; j++) begin
      if (sel == BW'(j)) addr = AW'(branch_base(j, M)) + AW'(r_ptr[j]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/interleave_ctrl.sv
`default_nettype none
// ============================================================================
// Module : interleave_ctrl
// DVB convolutional interleaver sequencer: commutator, FIFO addressing, output mux.
// Rev    : 1.0
// ============================================================================
module interleave_ctrl
  import interleave_pkg::*;
#(
  parameter int I  = c_i,
  parameter int M  = c_m,
  parameter int DW = c_dw,
  parameter int AW = c_aw,
  parameter int PW = c_pw
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  input  logic          din_vld,
  input  logic          syn_in,
  output logic [AW-1:0] ram_rd_addr,
  input  logic [DW-1:0] ram_rd_data,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_wr_addr,
  output logic [DW-1:0] ram_wr_data,
  output logic [DW-1:0] dout_byte,
  output logic          dout_vld,
  output logic          syn_out,
  output logic          fill_done,
  output logic          sync_err
);

  localparam int c_bw   = $clog2(I);
  localparam int c_fill = M * I * (I - 1);
  localparam int c_fw   = $clog2(c_fill + 1);

  state_t          r_state, w_state_nxt;
  logic [c_bw-1:0] r_branch, w_branch_eff, w_branch_nxt;
  logic            w_accept, w_ram_visit;
  logic [AW-1:0]   w_bank_addr, r_rd_addr_hold, r_wr_addr;
  logic [c_fw-1:0] r_fill_cnt;
  logic [DW-1:0]   r_din;
  logic            r_dout_vld, r_from_ram, r_syn_out, r_sync_err, r_wr_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (din_vld && syn_in) begin
          w_accept    = 1'b1;
          w_state_nxt = RUN;
        end
      end
      RUN:     w_accept = din_vld;
      default: w_state_nxt = IDLE;
    endcase
    // A sync byte always realigns the commutator onto branch 0
    w_branch_eff = syn_in ? '0 : r_branch;
    w_ram_visit  = w_accept && (w_branch_eff != '0);
    w_branch_nxt = (w_branch_eff == c_bw'(I - 1)) ? '0 : w_branch_eff + 1'b1;
  end

  interleave_ptr_bank #(
    .I (I),
    .M (M),
    .AW(AW),
    .PW(PW),
    .BW(c_bw)
  ) u_ptr_bank (
    .clk  (clk),
    .rst_n(rst_n),
    .adv  (w_ram_visit),
    .sel  (w_branch_eff),
    .addr (w_bank_addr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_branch       <= '0;
      r_fill_cnt     <= '0;
      r_din          <= '0;
      r_dout_vld     <= 1'b0;
      r_from_ram     <= 1'b0;
      r_syn_out      <= 1'b0;
      r_sync_err     <= 1'b0;
      r_wr_en        <= 1'b0;
      r_wr_addr      <= '0;
      r_rd_addr_hold <= '0;
    end else begin
      r_dout_vld <= w_accept;
      r_wr_en    <= w_ram_visit;
      r_syn_out  <= w_accept && syn_in;
      r_sync_err <= w_accept && syn_in && (r_state == RUN) && (r_branch != '0);
      if (w_accept) begin
        r_branch   <= w_branch_nxt;
        r_din      <= din;
        r_from_ram <= w_ram_visit;
        if (r_fill_cnt != c_fw'(c_fill)) r_fill_cnt <= r_fill_cnt + 1'b1;
      end
      if (w_ram_visit) begin
        r_wr_addr      <= w_bank_addr;
        r_rd_addr_hold <= w_bank_addr;
      end
    end
  end

  // Read address goes out in the visit cycle so RAM data lines up one cycle later
  assign ram_rd_addr = w_ram_visit ? w_bank_addr : r_rd_addr_hold;
  assign ram_wr_en   = r_wr_en;
  assign ram_wr_addr = r_wr_addr;
  assign ram_wr_data = r_din;
  assign dout_byte   = !r_dout_vld ? '0 : (r_from_ram ? ram_rd_data : r_din);
  assign dout_vld    = r_dout_vld;
  assign syn_out     = r_syn_out;
  assign sync_err    = r_sync_err;
  assign fill_done   = (r_fill_cnt == c_fw'(c_fill));

endmodule
`default_nettype wire

// File: tb/tb_interleave_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_interleave_ctrl
// Directed bench for interleave_ctrl with external RAM and interleaver model.
// Rev    : 1.0
// ============================================================================
module tb_interleave_ctrl;

  localparam int NB   = 12;
  localparam int MD   = 17;
  localparam int FILL = 2244;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din_vld = 1'b0;
  logic        syn_in = 1'b0;
  logic [7:0]  din = 8'h00;
  logic [7:0]  ram_rd_data, ram_wr_data, dout_byte;
  logic [10:0] ram_rd_addr, ram_wr_addr;
  logic        ram_wr_en, dout_vld, syn_out, fill_done, sync_err;
  logic [7:0]  mem [2048] = '{default: 8'h00};

  interleave_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .din_vld    (din_vld),
    .syn_in     (syn_in),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data),
    .ram_wr_en  (ram_wr_en),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .dout_byte  (dout_byte),
    .dout_vld   (dout_vld),
    .syn_out    (syn_out),
    .fill_done  (fill_done),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= mem[ram_rd_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;
  int acc_cnt  = 0;

  // Reference interleaver: branch j is a plain j*MD-deep byte queue
  logic [7:0]  fifo [NB][$];
  int          m_ptr [NB];
  int          m_b, m_fill, m_rd_hold;
  logic        m_run, m_vld, m_syn, m_err, m_wr_en;
  logic [7:0]  m_dout, m_wr_data;
  logic [10:0] m_wr_addr;

  logic [42:0] obs_vec, exp_vec;
  logic [10:0] obs_rd;
  logic [7:0]  obs_dout;
  logic        obs_vld, obs_syn, obs_err, obs_wr_en, obs_fill;

  task automatic model_reset();
    m_run = 1'b0; m_b = 0; m_fill = 0; m_rd_hold = 0;
    m_vld = 1'b0; m_syn = 1'b0; m_err = 1'b0; m_wr_en = 1'b0;
    m_dout = 8'h00; m_wr_data = 8'h00; m_wr_addr = 11'h0;
    acc_cnt = 0; pos = 0;
    for (int j = 0; j < NB; j++) begin
      fifo[j].delete();
      m_ptr[j] = 0;
      for (int k = 0; k < j * MD; k++) fifo[j].push_back(8'h00);
    end
  endtask

  // Drives one byte slot (entered at posedge+1), snapshots DUT and model, advances model
  task automatic drive_cycle(input logic v, input logic s, input logic [7:0] d);
    logic        acc;
    int          b;
    logic [10:0] e_rd;
    din_vld = v; syn_in = s; din = d;
    #1;
    acc  = v && (m_run || s);
    b    = s ? 0 : m_b;
    e_rd = (acc && b != 0) ? 11'(MD * b * (b - 1) / 2 + m_ptr[b]) : 11'(m_rd_hold);
    obs_rd = ram_rd_addr; obs_dout = dout_byte; obs_vld = dout_vld;
    obs_syn = syn_out; obs_err = sync_err; obs_wr_en = ram_wr_en; obs_fill = fill_done;
    obs_vec = {dout_vld, syn_out, sync_err, ram_wr_en, fill_done,
               m_vld ? dout_byte : 8'h00, m_wr_en ? ram_wr_addr : 11'h0,
               m_wr_en ? ram_wr_data : 8'h00, ram_rd_addr};
    exp_vec = {m_vld, m_syn, m_err, m_wr_en, (m_fill >= FILL),
               m_vld ? m_dout : 8'h00, m_wr_en ? m_wr_addr : 11'h0,
               m_wr_en ? m_wr_data : 8'h00, e_rd};
    m_err   = acc && s && m_run && (m_b != 0);
    m_vld   = acc;
    m_syn   = acc && s;
    m_wr_en = acc && (b != 0);
    if (acc) begin
      if (b == 0) begin
        m_dout = d;
      end else begin
        m_dout = fifo[b].pop_front();
        fifo[b].push_back(d);
        m_wr_addr = e_rd; m_wr_data = d; m_rd_hold = int'(e_rd);
        m_ptr[b] = (m_ptr[b] + 1) % (b * MD);
      end
      m_b = (b + 1) % NB;
      if (m_fill < FILL) m_fill++;
      m_run = 1'b1;
      acc_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_stream();
    drive_cycle(1'b1, pos == 0, 8'(pos));
    pos = (pos + 1) % 204;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; din_vld = 1'b1; syn_in = 1'b0; din = 8'h33;
    repeat (2) @(posedge clk);
    #2;
    n_checks++;
    if ({ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data, dout_byte,
         dout_vld, syn_out, fill_done, sync_err} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {ram_rd_addr, ram_wr_en, ram_wr_addr,
               ram_wr_data, dout_byte, dout_vld, syn_out, fill_done, sync_err});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive_cycle(1'b1, 1'b0, 8'hA0 + 8'(k));
      n_checks++;
      if ({obs_wr_en, obs_vld} !== 2'b00) begin
        n_fail++;
        $display("FAIL idle_drop[%0d]: wr_en/dout_vld got %b required 00", k, {obs_wr_en, obs_vld});
      end
    end
  endtask

  task automatic test_first_packet();
    logic [10:0] exp_addr [4] = '{11'd0, 11'd17, 11'd51, 11'd102};
    int idx;
    for (int k = 0; k < 207; k++) begin
      idx = acc_cnt;
      drive_stream();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL first_pkt_model[%0d]: got %h required %h", idx, obs_vec, exp_vec);
      end
      if (idx >= 1 && idx <= 4) begin
        n_checks++;
        if (obs_rd !== exp_addr[idx-1]) begin
          n_fail++;
          $display("FAIL first_rd_addr[%0d]: got %0d required %0d", idx, obs_rd, exp_addr[idx-1]);
        end
      end
      if (idx == 1) begin
        n_checks++;
        if ({obs_vld, obs_syn, obs_dout} !== {1'b1, 1'b1, 8'h00}) begin
          n_fail++;
          $display("FAIL first_dout: got vld=%b syn=%b dout=%h required 1 1 00", obs_vld, obs_syn, obs_dout);
        end
      end
      if (idx == 2) begin
        n_checks++;
        if (obs_syn !== 1'b0) begin
          n_fail++;
          $display("FAIL syn_out_byte1: got %b required 0", obs_syn);
        end
      end
      if (idx == 193 || idx == 205) begin
        n_checks++;
        if (obs_rd !== ((idx == 193) ? 11'd16 : 11'd0)) begin
          n_fail++;
          $display("FAIL br1_wrap_addr[%0d]: got %0d required %0d", idx, obs_rd, (idx == 193) ? 16 : 0);
        end
      end
      if (idx == 206) begin
        n_checks++;
        if ({obs_vld, obs_dout} !== {1'b1, 8'h01}) begin
          n_fail++;
          $display("FAIL br1_wrap_dout: got vld=%b dout=%h required 1 01", obs_vld, obs_dout);
        end
      end
    end
  endtask

  task automatic test_fill_done();
    int idx;
    for (int k = 0; k < 4100; k++) begin
      idx = acc_cnt;
      drive_stream();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL fill_model[%0d]: got %h required %h", idx, obs_vec, exp_vec);
      end
      if (idx == 2243 || idx == 2244) begin
        n_checks++;
        if (obs_fill !== (idx == 2244)) begin
          n_fail++;
          $display("FAIL fill_edge[%0d]: got %b required %b", idx, obs_fill, idx == 2244);
        end
      end
      if (idx == 2243 || idx == 2255) begin
        n_checks++;
        if (obs_rd !== ((idx == 2243) ? 11'd1121 : 11'd935)) begin
          n_fail++;
          $display("FAIL br11_addr[%0d]: got %0d required %0d", idx, obs_rd, (idx == 2243) ? 1121 : 935);
        end
      end
    end
  endtask

  task automatic test_gap();
    logic [10:0] hold;
    for (int k = 0; k < NB && m_b == 0; k++) drive_stream();
    drive_stream();
    hold = obs_rd;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive_cycle(1'b0, 1'b0, 8'hEE);
      else       drive_stream();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL gap_model[%0d]: got %h required %h", k, obs_vec, exp_vec);
      end
      if (k < 3) begin
        n_checks++;
        if (obs_rd !== hold) begin
          n_fail++;
          $display("FAIL gap_rd_hold[%0d]: got %0d required %0d", k, obs_rd, hold);
        end
      end
      if (k > 0) begin
        n_checks++;
        if ({obs_vld, obs_wr_en} !== 2'b00) begin
          n_fail++;
          $display("FAIL gap_idle[%0d]: vld/wr_en got %b required 00", k, {obs_vld, obs_wr_en});
        end
      end
    end
    for (int k = 0; k < 30; k++) begin
      drive_stream();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL post_gap_model[%0d]: got %h required %h", k, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_sync_err();
    int p1;
    for (int k = 0; k < NB && m_b != 5; k++) drive_stream();
    p1 = m_ptr[1];
    drive_cycle(1'b1, 1'b1, 8'h5A);
    pos = 1;
    n_checks++;
    if (obs_vec !== exp_vec) begin
      n_fail++;
      $display("FAIL sync_inject_model: got %h required %h", obs_vec, exp_vec);
    end
    drive_stream();
    n_checks++;
    if ({obs_err, obs_syn, obs_vld, obs_dout} !== {1'b1, 1'b1, 1'b1, 8'h5A}) begin
      n_fail++;
      $display("FAIL sync_err_pulse: got err=%b syn=%b vld=%b dout=%h required 1 1 1 5a",
               obs_err, obs_syn, obs_vld, obs_dout);
    end
    n_checks++;
    if (obs_rd !== 11'(p1)) begin
      n_fail++;
      $display("FAIL sync_next_branch1: rd_addr got %0d required %0d", obs_rd, p1);
    end
    for (int k = 0; k < 240; k++) begin
      drive_stream();
      n_checks++;
      if (obs_vec !== exp_vec) begin
        n_fail++;
        $display("FAIL post_sync_model[%0d]: got %h required %h", k, obs_vec, exp_vec);
      end
    end
  endtask

  task automatic test_reset_midstream();
    din_vld = 1'b1; syn_in = 1'b0; din = 8'h77;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({ram_rd_addr, ram_wr_en, ram_wr_addr, ram_wr_data, dout_byte,
         dout_vld, syn_out, fill_done, sync_err} !== '0) begin
      n_fail++;
      $display("FAIL midstream_reset: got %h required 0", {ram_rd_addr, ram_wr_en, ram_wr_addr,
               ram_wr_data, dout_byte, dout_vld, syn_out, fill_done, sync_err});
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_first_packet();
    test_fill_done();
    test_gap();
    test_sync_err();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
